// File: rtl/wishbone_spi_initiator.sv
`default_nettype none
// wishbone_spi_initiator: Wishbone classic slave carrying each access as one SPI mode-0 frame to a remote target.
// Optional poll timeout with err_o is enabled by defining WISHBONE_SPI_INITIATOR_TIMEOUT_EN.
module wishbone_spi_initiator #(
   parameter int CLK_DIV    = 8,
   parameter int GAP_CYCLES = 16,
   parameter int MAX_POLL   = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [22:0] adr_i,
   input  logic [7:0]  dat_i,
   output logic [7:0]  dat_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        spi_sck,
   output logic        spi_ss_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   localparam int POLL_W = $clog2(MAX_POLL + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CMD, POLL, DATA, DONE, GAP} state_t;

   state_t            state_q, state_d;
   logic [31:0]       sr_q, sr_d;
   logic [7:0]        rx_q, rx_d;
   logic [7:0]        dat_q, dat_d;
   logic [7:0]        div_q, div_d;
   logic [5:0]        bit_q, bit_d;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              sck_q, sck_d;
   logic              ss_n_q, ss_n_d;
   logic              mosi_q, mosi_d;
   logic              ack_q, ack_d;
   logic              miso_meta_q, miso_sync_q;
   logic              active;
   logic              high_end;

   // Last clk cycle of an SCK high phase: MISO sample point and MOSI advance point.
   assign active   = (state_q == CMD) || (state_q == POLL) || (state_q == DATA);
   assign high_end = sck_q && (div_q == DIV_LAST);

`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
   logic err_q, err_d;
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      rx_d    = rx_q;
      dat_d   = dat_q;
      div_d   = div_q;
      bit_d   = bit_q;
      poll_d  = poll_q;
      gap_d   = gap_q;
      sck_d   = sck_q;
      ss_n_d  = ss_n_q;
      mosi_d  = mosi_q;
      ack_d   = 1'b0;
`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
      err_d   = 1'b0;
`endif
      if (active) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            sck_d = ~sck_q;
         end else begin
            div_d = div_q + 8'd1;
         end
      end
      case (state_q)
         IDLE: begin
            if (cyc_i && stb_i) begin
               sr_d    = {we_i, adr_i, dat_i};
               mosi_d  = we_i;
               ss_n_d  = 1'b0;
               sck_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               poll_d  = '0;
               state_d = CMD;
            end
         end
         CMD: begin
            if (high_end) begin
               sr_d   = {sr_q[30:0], 1'b0};
               mosi_d = sr_q[30];
               bit_d  = bit_q + 6'd1;
               if (bit_q == 6'd31) begin
                  mosi_d  = 1'b0;
                  bit_d   = '0;
                  state_d = POLL;
               end
            end
         end
         POLL: begin
            if (high_end) begin
               if (miso_sync_q) begin
                  state_d = DATA;
               end else begin
`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
                  poll_d = poll_q + 1'b1;
                  if (poll_q == POLL_W'(MAX_POLL - 1)) begin
                     err_d   = 1'b1;
                     ss_n_d  = 1'b1;
                     sck_d   = 1'b0;
                     div_d   = '0;
                     gap_d   = '0;
                     state_d = GAP;
                  end
`else
                  if (poll_q != '1) poll_d = poll_q + 1'b1;
`endif
               end
            end
         end
         DATA: begin
            if (high_end) begin
               rx_d  = {rx_q[6:0], miso_sync_q};
               bit_d = bit_q + 6'd1;
               if (bit_q == 6'd7) begin
                  bit_d   = '0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            dat_d   = rx_q;
            ack_d   = 1'b1;
            sck_d   = 1'b0;
            ss_n_d  = 1'b1;
            div_d   = '0;
            gap_d   = '0;
            state_d = GAP;
         end
         GAP: begin
            sck_d  = 1'b0;
            ss_n_d = 1'b1;
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A dropped cycle abandons the frame silently; the target resets on ss_n high.
      if (active && !cyc_i) begin
         ss_n_d  = 1'b1;
         sck_d   = 1'b0;
         mosi_d  = 1'b0;
         div_d   = '0;
         bit_d   = '0;
         gap_d   = '0;
`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
         err_d   = 1'b0;
`endif
         state_d = GAP;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         rx_q        <= '0;
         dat_q       <= '0;
         div_q       <= '0;
         bit_q       <= '0;
         poll_q      <= '0;
         gap_q       <= '0;
         sck_q       <= 1'b0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ack_q       <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         rx_q        <= rx_d;
         dat_q       <= dat_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         poll_q      <= poll_d;
         gap_q       <= gap_d;
         sck_q       <= sck_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         ack_q       <= ack_d;
         miso_meta_q <= spi_miso;
         miso_sync_q <= miso_meta_q;
      end
   end

`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end
`endif

   assign dat_o    = dat_q;
   assign ack_o    = ack_q;
   assign spi_sck  = sck_q;
   assign spi_ss_n = ss_n_q;
   assign spi_mosi = mosi_q;
endmodule
`default_nettype wire

// File: tb/tb_wishbone_spi_initiator.sv
`default_nettype none
// tb_wishbone_spi_initiator: randomized self-checking bench with a behavioural SPI target model.
// Exercises the timeout path when WISHBONE_SPI_INITIATOR_TIMEOUT_EN is defined.
module tb_wishbone_spi_initiator;
   localparam int CD   = 6;
   localparam int GAPC = 16;
   localparam int MAXP = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [22:0] adr_i = '0;
   logic [7:0]  dat_i = '0;
   logic [7:0]  dat_o;
   logic        ack_o, err_o, spi_sck, spi_ss_n, spi_mosi;
   logic        spi_miso;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_dat = 8'h00;

   wishbone_spi_initiator #(.CLK_DIV(CD), .GAP_CYCLES(GAPC), .MAX_POLL(MAXP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
      .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   // Target model: captures the command on SCK rises, answers with N zeros, a start bit, then the byte.
   int          bfm_zeros = 0;
   logic [7:0]  bfm_byte  = 8'h00;
   int          rise_cnt, fall_cnt;
   logic [31:0] cmd_cap;
   logic        sck_prev, miso_next, miso_p1;

   function automatic logic resp_bit(input int k, input int zeros, input logic [7:0] b);
      if (k < zeros)       return 1'b0;
      if (k == zeros)      return 1'b1;
      if (k <= zeros + 8)  return b[7 - (k - zeros - 1)];
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         rise_cnt <= 0; fall_cnt <= 0; cmd_cap <= '0; sck_prev <= 1'b0;
         miso_next <= 1'b0; miso_p1 <= 1'b0; spi_miso <= 1'b0;
      end else begin
         sck_prev <= spi_sck;
         miso_p1  <= miso_next;
         spi_miso <= miso_p1;
         if (spi_ss_n) begin
            rise_cnt <= 0; fall_cnt <= 0; miso_next <= 1'b0;
         end else begin
            if (spi_sck && !sck_prev) begin
               if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], spi_mosi};
               rise_cnt <= rise_cnt + 1;
            end
            if (!spi_sck && sck_prev) begin
               fall_cnt <= fall_cnt + 1;
               if (fall_cnt + 1 >= 32) miso_next <= resp_bit(fall_cnt + 1 - 32, bfm_zeros, bfm_byte);
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Presents one request and waits (bounded) for ack_o or err_o; lat counts clocks from the sampling edge.
   task automatic wb_access(input logic we, input logic [22:0] adr, input logic [7:0] dat,
                            input int zeros, input logic [7:0] resp,
                            output int lat, output logic got_ack, output logic got_err);
      bfm_zeros = zeros; bfm_byte = resp;
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
      lat = -1; got_ack = 1'b0; got_err = 1'b0;
      for (int n = 1; n <= 8000; n++) begin
         @(negedge clk);
         if (ack_o || err_o) begin
            lat = n - 1; got_ack = ack_o; got_err = err_o;
            break;
         end
      end
      cyc_i = 1'b0; stb_i = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (dat_o !== 8'h00)  begin n_fail++; $display("FAIL reset_dat_o got=%h exp=00", dat_o); end
      n_checks++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
      n_checks++; if (err_o !== 1'b0)   begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
      n_checks++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
      n_checks++; if (spi_ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n got=%b exp=1", spi_ss_n); end
      n_checks++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
   endtask

   task automatic test_write();
      int lat; logic a, e; logic [31:0] exp_cmd;
      exp_cmd = {1'b1, 23'h12_3456, 8'hA5};
      idle(GAPC + 2);
      wb_access(1'b1, 23'h12_3456, 8'hA5, 2, 8'h3C, lat, a, e);
      exp_dat = 8'h3C;
      n_checks++; if (!(a === 1'b1 && e === 1'b0)) begin n_fail++; $display("FAIL write_ack ack=%b err=%b exp ack=1 err=0", a, e); end
      n_checks++; if (cmd_cap !== exp_cmd) begin n_fail++; $display("FAIL write_mosi got=%h exp=%h", cmd_cap, exp_cmd); end
      n_checks++; if (dat_o !== exp_dat) begin n_fail++; $display("FAIL write_dat_o got=%h exp=%h", dat_o, exp_dat); end
      n_checks++; if (lat !== (32 + 2 + 1 + 8) * 2 * CD + 1) begin n_fail++; $display("FAIL write_latency got=%0d exp=%0d", lat, (43 * 2 * CD) + 1); end
      @(negedge clk);
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL write_ack_single got=%b exp=0", ack_o); end
   endtask

   task automatic test_read_min();
      int lat; logic a, e;
      idle(GAPC + 2);
      wb_access(1'b0, 23'h00_0001, 8'h00, 0, 8'hFF, lat, a, e);
      exp_dat = 8'hFF;
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_min_ack got=%b exp=1", a); end
      n_checks++; if (lat !== 41 * 2 * CD + 1) begin n_fail++; $display("FAIL read_min_latency got=%0d exp=%0d", lat, 41 * 2 * CD + 1); end
      n_checks++; if (dat_o !== exp_dat) begin n_fail++; $display("FAIL read_min_dat_o got=%h exp=%h", dat_o, exp_dat); end
      n_checks++; if (cmd_cap !== {1'b0, 23'h00_0001, 8'h00}) begin n_fail++; $display("FAIL read_min_mosi got=%h exp=%h", cmd_cap, {1'b0, 23'h00_0001, 8'h00}); end
   endtask

   task automatic test_random();
      int lat; logic a, e; logic we; logic [22:0] adr; logic [7:0] dat, resp; int z;
      for (int t = 0; t < 6; t++) begin
         we = 1'($urandom); adr = 23'($urandom); dat = 8'($urandom); resp = 8'($urandom);
         z = int'($urandom_range(0, 3));
         idle(GAPC + 2);
         wb_access(we, adr, dat, z, resp, lat, a, e);
         exp_dat = resp;
         n_checks++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL rand%0d_ack ack=%b err=%b exp ack=1 err=0", t, a, e); end
         n_checks++; if (cmd_cap !== {we, adr, dat}) begin n_fail++; $display("FAIL rand%0d_mosi got=%h exp=%h", t, cmd_cap, {we, adr, dat}); end
         n_checks++; if (dat_o !== exp_dat) begin n_fail++; $display("FAIL rand%0d_dat_o got=%h exp=%h", t, dat_o, exp_dat); end
         n_checks++; if (lat !== (41 + z) * 2 * CD + 1) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, (41 + z) * 2 * CD + 1); end
      end
   endtask

   task automatic test_back_to_back();
      int gap; int acks; logic timed_out;
      idle(GAPC + 2);
      bfm_zeros = 1; bfm_byte = 8'h5A;
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 23'h2A_AAAA; dat_i = 8'h11;
      acks = 0; timed_out = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (ack_o) begin acks++; timed_out = 1'b0; break; end
      end
      n_checks++; if (timed_out !== 1'b0 || dat_o !== 8'h5A) begin n_fail++; $display("FAIL b2b_first_dat_o got=%h exp=5a timeout=%b", dat_o, timed_out); end
      bfm_zeros = 3; bfm_byte = 8'hC3;
      gap = 0;
      while (spi_ss_n === 1'b1 && gap < 1000) begin @(negedge clk); gap++; end
      n_checks++; if (gap < GAPC) begin n_fail++; $display("FAIL b2b_gap got=%0d exp>=%0d", gap, GAPC); end
      timed_out = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (ack_o) begin acks++; timed_out = 1'b0; break; end
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      exp_dat = 8'hC3;
      n_checks++; if (timed_out !== 1'b0 || dat_o !== exp_dat) begin n_fail++; $display("FAIL b2b_second_dat_o got=%h exp=%h timeout=%b", dat_o, exp_dat, timed_out); end
      n_checks++; if (acks !== 2 || cmd_cap !== {1'b0, 23'h2A_AAAA, 8'h11}) begin n_fail++; $display("FAIL b2b_cmd acks=%0d cmd=%h exp acks=2 cmd=%h", acks, cmd_cap, {1'b0, 23'h2A_AAAA, 8'h11}); end
   endtask

   task automatic test_abort();
      int lat; logic a, e; int seen; int w;
      idle(GAPC + 2);
      bfm_zeros = 0; bfm_byte = 8'h77;
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 23'h05_0505; dat_i = 8'h99;
      w = 0;
      while (rise_cnt < 10 && w < 2000) begin @(negedge clk); w++; end
      cyc_i = 1'b0; stb_i = 1'b0;
      @(negedge clk);
      n_checks++; if (spi_ss_n !== 1'b1 || spi_sck !== 1'b0) begin n_fail++; $display("FAIL abort_pins ss_n=%b sck=%b exp ss_n=1 sck=0", spi_ss_n, spi_sck); end
      seen = 0;
      for (int i = 0; i < GAPC + 10; i++) begin @(negedge clk); if (ack_o || err_o) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp got=%0d pulses exp=0", seen); end
      n_checks++; if (dat_o !== exp_dat) begin n_fail++; $display("FAIL abort_dat_o got=%h exp=%h", dat_o, exp_dat); end
      wb_access(1'b0, 23'h05_0506, 8'h00, 1, 8'h81, lat, a, e);
      exp_dat = 8'h81;
      n_checks++; if (a !== 1'b1 || dat_o !== exp_dat) begin n_fail++; $display("FAIL abort_after_read ack=%b dat_o=%h exp ack=1 dat_o=%h", a, dat_o, exp_dat); end
   endtask

   task automatic test_timeout();
      idle(GAPC + 2);
`ifdef WISHBONE_SPI_INITIATOR_TIMEOUT_EN
      begin
         int lat; logic a, e;
         wb_access(1'b0, 23'h7F_FFFF, 8'h00, 100000, 8'h00, lat, a, e);
         n_checks++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL timeout_err err=%b ack=%b exp err=1 ack=0", e, a); end
         n_checks++; if (lat !== (32 + MAXP) * 2 * CD) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, (32 + MAXP) * 2 * CD); end
         n_checks++; if (dat_o !== exp_dat) begin n_fail++; $display("FAIL timeout_dat_o got=%h exp=%h", dat_o, exp_dat); end
         @(negedge clk);
         n_checks++; if (err_o !== 1'b0 || spi_ss_n !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse err=%b ss_n=%b exp err=0 ss_n=1", err_o, spi_ss_n); end
      end
`else
      begin
         int seen; int w;
         bfm_zeros = 100000; bfm_byte = 8'h00;
         @(negedge clk);
         cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 23'h7F_FFFF; dat_i = 8'h00;
         seen = 0; w = 0;
         while (fall_cnt < 32 + 1000 && w < 1040 * 2 * CD) begin
            @(negedge clk); w++;
            if (ack_o || err_o) seen++;
         end
         n_checks++; if (fall_cnt < 32 + 1000) begin n_fail++; $display("FAIL no_timeout_progress got=%0d exp>=%0d", fall_cnt, 1032); end
         n_checks++; if (seen !== 0 || spi_ss_n !== 1'b0) begin n_fail++; $display("FAIL no_timeout_quiet pulses=%0d ss_n=%b exp pulses=0 ss_n=0", seen, spi_ss_n); end
         cyc_i = 1'b0; stb_i = 1'b0;
         idle(2);
      end
`endif
   endtask

   task automatic test_reset_mid_data();
      int lat; logic a, e; int w;
      idle(GAPC + 2);
      bfm_zeros = 1; bfm_byte = 8'hE7;
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 23'h11_1111; dat_i = 8'h00;
      w = 0;
      while (fall_cnt < 37 && w < 2000) begin @(negedge clk); w++; end
      n_checks++; if (fall_cnt < 37) begin n_fail++; $display("FAIL rst_mid_reach got=%0d exp>=37", fall_cnt); end
      #2 rst_n = 1'b0;
      #1;
      exp_dat = 8'h00;
      n_checks++; if (spi_ss_n !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_pins ss_n=%b sck=%b mosi=%b exp 1 0 0", spi_ss_n, spi_sck, spi_mosi); end
      n_checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== exp_dat)
         begin n_fail++; $display("FAIL rst_mid_outs ack=%b err=%b dat_o=%h exp 0 0 00", ack_o, err_o, dat_o); end
      cyc_i = 1'b0; stb_i = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      wb_access(1'b1, 23'h22_2222, 8'h3E, 2, 8'h4D, lat, a, e);
      exp_dat = 8'h4D;
      n_checks++; if (a !== 1'b1 || dat_o !== exp_dat || lat !== 43 * 2 * CD + 1)
         begin n_fail++; $display("FAIL rst_mid_after ack=%b dat_o=%h lat=%0d exp ack=1 dat_o=%h lat=%0d", a, dat_o, lat, exp_dat, 43 * 2 * CD + 1); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle(3);
      test_reset();
      rst_n = 1'b1;
      test_write();
      test_read_min();
      test_random();
      test_back_to_back();
      test_abort();
      test_timeout();
      test_reset_mid_data();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
